// File: rtl/microprocessor_pkg.sv
// Shared constants for the memory-mapped interrupt controller:
// register word addresses, VECTOR layout and source index width.
package microprocessor_pkg;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_VECTOR  = 3'd3;
    localparam logic [2:0] ADDR_ACK     = 3'd4;
    localparam logic [2:0] ADDR_SWTRIG  = 3'd5;

    localparam int VECTOR_VALID_BIT = 15;
    localparam int IRQ_IDX_W        = 4;

endpackage

// File: rtl/microprocessor_irq_ctrl_if.sv
// Avalon-MM slave bus bundle: 3-bit word address, 16-bit data,
// registered read data returned one cycle after the address.
interface microprocessor_irq_ctrl_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest request bit,
// valid when any bit is set; index is 0 when nothing is requested.
module irq_prio_enc
    import microprocessor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]     req,
    output logic [IRQ_IDX_W-1:0] index,
    output logic                 valid
);

    // NOTE: every output of a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        index = '0;
        valid = |req;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = i[IRQ_IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/microprocessor_irq_ctrl.sv
// Interrupt controller: edge/level request capture, masking, lowest-index
// priority, registered irq_out and a registered Avalon-MM read mux.
module microprocessor_irq_ctrl
    import microprocessor_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IRQ-1:0]         irq_in,
    microprocessor_irq_ctrl_if.slave   bus,
    output logic                       irq_out
);

    logic [NUM_IRQ-1:0]   irq_dly_q, irq_dly_d;
    logic [NUM_IRQ-1:0]   stored_q, stored_d;
    logic [NUM_IRQ-1:0]   enable_q, enable_d;
    logic [NUM_IRQ-1:0]   edge_q, edge_d;
    logic [15:0]          readdata_q, readdata_d;
    logic                 irq_out_q, irq_out_d;

    logic                 wr_en;
    logic [NUM_IRQ-1:0]   rise, set_mask, clr_mask;
    logic [NUM_IRQ-1:0]   pending, active;
    logic [IRQ_IDX_W-1:0] vec_idx;
    logic                 vec_valid;
    logic [15:0]          pending_ext, enable_ext, edge_ext;
    logic                 unused_wdata;

    assign unused_wdata = &{1'b0, bus.writedata};

    // Level sources are never stored; they follow irq_in directly.
    assign pending = (stored_q & edge_q) | (irq_in & ~edge_q);
    assign active  = pending & enable_q;

    irq_prio_enc #(
        .WIDTH (NUM_IRQ)
    ) u_prio_enc (
        .req   (active),
        .index (vec_idx),
        .valid (vec_valid)
    );

    always_comb begin
        wr_en     = bus.chipselect & ~bus.write_n;
        irq_dly_d = irq_in;
        rise      = irq_in & ~irq_dly_q;
        set_mask  = rise;
        clr_mask  = '0;
        enable_d  = enable_q;
        edge_d    = edge_q;

        if (wr_en) begin
            case (bus.address)
                ADDR_PENDING: clr_mask = bus.writedata[NUM_IRQ-1:0];
                ADDR_ENABLE:  enable_d = bus.writedata[NUM_IRQ-1:0];
                ADDR_EDGE:    edge_d   = bus.writedata[NUM_IRQ-1:0];
                ADDR_ACK: begin
                    // Indices at or above NUM_IRQ match no bit and are ignored.
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (bus.writedata[IRQ_IDX_W-1:0] == i[IRQ_IDX_W-1:0]) begin
                            clr_mask[i] = 1'b1;
                        end
                    end
                end
                ADDR_SWTRIG:  set_mask = rise | bus.writedata[NUM_IRQ-1:0];
                default: ;
            endcase
        end

        // Set beats clear; masking with old and new EDGE drops the stored bit
        // on 1->0 and keeps a 0->1 switch from latching a phantom edge.
        stored_d  = ((stored_q & ~clr_mask) | set_mask) & edge_q & edge_d;
        irq_out_d = vec_valid;
    end

    always_comb begin
        pending_ext                = '0;
        enable_ext                 = '0;
        edge_ext                   = '0;
        pending_ext[NUM_IRQ-1:0]   = pending;
        enable_ext[NUM_IRQ-1:0]    = enable_q;
        edge_ext[NUM_IRQ-1:0]      = edge_q;
        readdata_d                 = '0;
        case (bus.address)
            ADDR_PENDING: readdata_d = pending_ext;
            ADDR_ENABLE:  readdata_d = enable_ext;
            ADDR_EDGE:    readdata_d = edge_ext;
            ADDR_VECTOR: begin
                readdata_d[VECTOR_VALID_BIT]   = vec_valid;
                readdata_d[IRQ_IDX_W-1:0]      = vec_idx;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_dly_q  <= '0;
            stored_q   <= '0;
            enable_q   <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            irq_dly_q  <= irq_dly_d;
            stored_q   <= stored_d;
            enable_q   <= enable_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_out_q  <= irq_out_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq_out      = irq_out_q;

endmodule

// File: tb/tb_microprocessor_irq_ctrl.sv
// Directed self-checking bench for microprocessor_irq_ctrl (NUM_IRQ = 8).
module tb_microprocessor_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    logic       irq_out;
    int         total;
    int         bad;

    microprocessor_irq_ctrl_if bus ();

    microprocessor_irq_ctrl #(
        .NUM_IRQ (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .bus     (bus.slave),
        .irq_out (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic test_reset;
        logic [15:0] rd;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_read(a[2:0], rd);
            total++;
            if (rd !== 16'h0000) begin
                bad++;
                $display("FAIL reset_read addr=%0d got=%h exp=0000", a, rd);
            end
        end
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq_out got=%b exp=0", irq_out);
        end
    endtask

    task automatic test_edge;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0001);
        bus_write(3'd1, 16'h0001);
        irq_in = 8'h01;
        @(negedge clk);
        irq_in = 8'h00;
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL edge_irq_early got=%b exp=0", irq_out);
        end
        @(negedge clk);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL edge_irq_rise got=%b exp=1", irq_out);
        end
        bus_read(3'd3, rd);
        total++;
        if (rd !== 16'h8000) begin
            bad++;
            $display("FAIL edge_vector got=%h exp=8000", rd);
        end
        bus_write(3'd4, 16'h0000);
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL ack_irq_hold got=%b exp=1", irq_out);
        end
        @(negedge clk);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL ack_irq_drop got=%b exp=0", irq_out);
        end
        bus_read(3'd0, rd);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("FAIL ack_pending got=%h exp=0000", rd);
        end
    endtask

    task automatic test_level;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0000);
        bus_write(3'd1, 16'h0030);
        irq_in = 8'h30;
        bus_read(3'd3, rd);
        total++;
        if (rd !== 16'h8004) begin
            bad++;
            $display("FAIL level_vector_4 got=%h exp=8004", rd);
        end
        irq_in = 8'h20;
        bus_read(3'd3, rd);
        total++;
        if (rd !== 16'h8005) begin
            bad++;
            $display("FAIL level_vector_5 got=%h exp=8005", rd);
        end
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL level_irq_high got=%b exp=1", irq_out);
        end
        irq_in = 8'h00;
        @(negedge clk);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL level_irq_drop got=%b exp=0", irq_out);
        end
    endtask

    task automatic test_swtrig;
        logic [15:0] rd;
        bus_write(3'd1, 16'h0000);
        bus_write(3'd2, 16'h00FF);
        bus_write(3'd5, 16'h0081);
        bus_read(3'd0, rd);
        total++;
        if (rd !== 16'h0081) begin
            bad++;
            $display("FAIL swtrig_pending got=%h exp=0081", rd);
        end
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL swtrig_masked_irq got=%b exp=0", irq_out);
        end
        bus_write(3'd4, 16'h0008);
        bus_read(3'd0, rd);
        total++;
        if (rd !== 16'h0081) begin
            bad++;
            $display("FAIL ack_out_of_range got=%h exp=0081", rd);
        end
        bus_write(3'd1, 16'h0080);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 16'h8007) begin
            bad++;
            $display("FAIL swtrig_vector_7 got=%h exp=8007", rd);
        end
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL late_enable_irq got=%b exp=1", irq_out);
        end
        bus_write(3'd1, 16'h0081);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 16'h8000) begin
            bad++;
            $display("FAIL prio_vector_0 got=%h exp=8000", rd);
        end
        bus_write(3'd4, 16'h0000);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 16'h8007) begin
            bad++;
            $display("FAIL back_to_back_vector got=%h exp=8007", rd);
        end
        bus_write(3'd0, 16'h0080);
        bus_read(3'd3, rd);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("FAIL vector_none got=%h exp=0000", rd);
        end
    endtask

    task automatic test_set_wins;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0004);
        @(negedge clk);
        irq_in         = 8'h04;
        bus.address    = 3'd0;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = 16'h0004;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus_read(3'd0, rd);
        total++;
        if (rd !== 16'h0004) begin
            bad++;
            $display("FAIL set_wins_pending got=%h exp=0004", rd);
        end
        irq_in = 8'h00;
        bus_read(3'd0, rd);
        total++;
        if (rd !== 16'h0004) begin
            bad++;
            $display("FAIL edge_held_pending got=%h exp=0004", rd);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rd;
        bus_write(3'd2, 16'h0003);
        bus_write(3'd1, 16'h0003);
        bus_write(3'd5, 16'h0003);
        bus_read(3'd0, rd);
        total++;
        if (rd !== 16'h0003) begin
            bad++;
            $display("FAIL mid_pending_before got=%h exp=0003", rd);
        end
        total++;
        if (irq_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_irq_before got=%b exp=1", irq_out);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (irq_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_irq got=%b exp=0", irq_out);
        end
        reset = 1'b0;
        bus_read(3'd0, rd);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset_pending got=%h exp=0000", rd);
        end
        bus_read(3'd1, rd);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("FAIL mid_reset_enable got=%h exp=0000", rd);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        irq_in         = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        test_reset();
        test_edge();
        test_level();
        test_swtrig();
        test_set_wins();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
